// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Stores to TXDATA (address[2]=0) enqueue data_in[7:0]; a serializer drains
// the FIFO onto uart_tx. Loads from STATUS (address[2]=1) return
// {count, overflow, busy, empty, full}; a store to STATUS with data_in[3]=1
// clears the sticky overflow flag.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   write_enable  store request, sampled on the rising edge of clk
//   read_enable   load request, sampled on the rising edge of clk
//   address       byte address, only address[2] is decoded
//   data_in       store data
//   data_out      registered load data, held until the next load
//   mem_ready     one-cycle request-complete pulse
//   uart_tx       serial line, idle high
//
// Bus handshake: every edge with write_enable|read_enable high executes the
// request (there is no back-pressure), and mem_ready is high for exactly the
// following cycle, in which data_out carries the load result. A store wins
// over a simultaneous load; the load is then ignored and data_out is kept.
module mmio_uart_tx #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam logic [CW-1:0] DELAY_CW  = CW'(DELAY_FRAMES);
  localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      tx_byte;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            overflow;

  logic            bit_done;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            wr_txdata;
  logic            wr_status;
  logic            rd_req;
  logic            push;
  logic            drop;
  logic [AW:0]     count_nxt;
  logic            busy_nxt;
  logic [31:0]     status;

  // Only address[2] and the low data byte carry meaning.
  logic unused_bits;
  assign unused_bits = ^{address[31:3], address[1:0], data_in[31:8]};

  always_comb begin
    bit_done   = (cnt + 1'b1) == DELAY_CW;
    fifo_empty = (count == '0);
    fifo_full  = (count == COUNT_MAX);

    // The serializer only sees the registered count, so a byte pushed at an
    // edge is available for popping one edge later.
    pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

    wr_txdata = write_enable && !address[2];
    wr_status = write_enable && address[2];
    rd_req    = read_enable && !write_enable;

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    push = wr_txdata && (!fifo_full || pop);
    drop = wr_txdata && fifo_full && !pop;

    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end

    // STATUS reports the post-edge view, so a pop on the load edge counts.
    if (state == IDLE) begin
      busy_nxt = pop;
    end else begin
      busy_nxt = !((state == STOP) && bit_done && !pop);
    end

    status             = '0;
    status[8 +: AW+1]  = count_nxt;
    status[3]          = overflow;
    status[2]          = busy_nxt;
    status[1]          = (count_nxt == '0);
    status[0]          = (count_nxt == COUNT_MAX);
  end

  // FIFO storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Bus response path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else begin
      mem_ready <= write_enable | read_enable;
      if (rd_req) begin
        data_out <= address[2] ? status : 32'd0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_status && data_in[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer. uart_tx is registered and is set to the level of the bit
  // being entered, so every bit lasts exactly DELAY_FRAMES cycles and a
  // STOP->START hand-off leaves no idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          cnt     <= '0;
          if (pop) begin
            tx_byte <= mem[rd_ptr];
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            uart_tx <= tx_byte[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (pop) begin
              tx_byte <= mem[rd_ptr];
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
